// File: rtl/tlx_intrp_pkg.sv
// tlx_intrp_pkg: opcodes, response codes, policy/state encodings and command record for the TLX interrupt responder
package tlx_intrp_pkg;
  localparam logic [7:0] OP_INTRP_REQ     = 8'h58;
  localparam logic [7:0] OP_INTRP_REQ_S   = 8'h59;
  localparam logic [7:0] OP_INTRP_REQ_D   = 8'h5A;
  localparam logic [7:0] OP_INTRP_REQ_D_S = 8'h5B;
  localparam logic [7:0] OP_INTRP_RESP    = 8'h0C;
  localparam logic [7:0] OP_INTRP_RDY     = 8'h1A;
  localparam logic [3:0] RC_DONE    = 4'h0;
  localparam logic [3:0] RC_RTY     = 4'h2;
  localparam logic [3:0] RC_PENDING = 4'h4;
  localparam logic [3:0] RC_FAILED  = 4'hE;
  typedef enum logic [1:0] {POL_DONE, POL_RETRY, POL_PENDING, POL_FAIL} policy_e;
  typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_RESP} state_e;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] afutag;
    logic [67:0] obj;
    logic [19:0] pasid;
    logic [11:0] actag;
  } intrp_cmd_t;
endpackage

// File: rtl/intrp_cmd_fifo.sv
// intrp_cmd_fifo: synchronous command FIFO; a push while full is accepted when a pop frees the head in the same cycle
module intrp_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 124
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/interrupt_tlx_responder.sv
// interrupt_tlx_responder: TLX-side responder answering AP intrp_req with intrp_resp/intrp_rdy and delivering host interrupts.
// Optional saturating per-code response counters when INTRP_RSP_STATS_EN is defined.
module interrupt_tlx_responder
  import tlx_intrp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_opcode,
  input  logic [15:0] cmd_afutag,
  input  logic [67:0] cmd_obj,
  input  logic [19:0] cmd_pasid,
  input  logic [11:0] cmd_actag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_opcode,
  output logic [15:0] rsp_afutag,
  output logic [3:0]  rsp_code,
  output logic        host_int_valid,
  output logic [63:0] host_int_obj,
  output logic [19:0] host_int_pasid,
  output logic [11:0] host_int_actag,
  input  logic [1:0]  cfg_policy,
  input  logic [3:0]  cfg_retry_n,
  input  logic [15:0] cfg_rdy_delay,
  input  logic        cfg_rdy_retry,
  output logic        err_overflow
`ifdef INTRP_RSP_STATS_EN
  ,
  output logic [31:0] stat_done,
  output logic [31:0] stat_retry,
  output logic [31:0] stat_pending,
  output logic [31:0] stat_fail
`endif
);
  intrp_cmd_t cmd_in, head, cur_q, slot_q;
  state_e state_q, state_d;
  policy_e pol;
  logic full, empty, pop, in_resp, rdy_vld, resp_fire, rdy_fire, deliver;
  logic slot_busy, slot_armed, unused_bits;
  logic [3:0] code_d, rsp_code_q, retry_cnt;
  logic [15:0] delay_cnt;
  assign cmd_in = '{cmd_opcode, cmd_afutag, cmd_obj, cmd_pasid, cmd_actag};
  intrp_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(intrp_cmd_t))) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(cmd_valid), .din(cmd_in), .pop(pop),
    .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  // intrp_rdy appears cfg_rdy_delay cycles after the pending response is accepted, never sooner than the next cycle
  always_comb begin
    pol = policy_e'(cfg_policy);
    in_resp = state_q == S_RESP;
    rdy_vld = state_q == S_IDLE && slot_armed && delay_cnt <= 16'd1;
    pop = state_q == S_IDLE && !empty && !rdy_vld;
    state_d = pop ? S_DECIDE : state_q == S_DECIDE ? S_RESP : in_resp && rsp_ready ? S_IDLE : state_q;
    code_d = cur_q.opcode != OP_INTRP_REQ ? RC_FAILED :
             pol == POL_DONE ? RC_DONE :
             pol == POL_FAIL ? RC_FAILED :
             pol == POL_RETRY ? (retry_cnt < cfg_retry_n ? RC_RTY : RC_DONE) :
             slot_busy ? RC_RTY : RC_PENDING;
    resp_fire = in_resp && rsp_ready;
    rdy_fire = rdy_vld && rsp_ready;
    deliver = (resp_fire && rsp_code_q == RC_DONE) || (rdy_fire && !cfg_rdy_retry);
    rsp_valid = in_resp || rdy_vld;
    rsp_opcode = in_resp ? OP_INTRP_RESP : rdy_vld ? OP_INTRP_RDY : 8'h00;
    rsp_afutag = in_resp ? cur_q.afutag : rdy_vld ? slot_q.afutag : 16'h0000;
    rsp_code = in_resp ? rsp_code_q : rdy_vld ? (cfg_rdy_retry ? RC_RTY : RC_DONE) : 4'h0;
    unused_bits = ^{cur_q.obj[67:64], slot_q.opcode, slot_q.obj[67:64]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      slot_q <= '0;
      rsp_code_q <= '0;
      retry_cnt <= '0;
      slot_busy <= 1'b0;
      slot_armed <= 1'b0;
      delay_cnt <= '0;
      host_int_valid <= 1'b0;
      host_int_obj <= '0;
      host_int_pasid <= '0;
      host_int_actag <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (pop) cur_q <= head;
      if (state_q == S_DECIDE) rsp_code_q <= code_d;
      if (state_q == S_DECIDE && cur_q.opcode == OP_INTRP_REQ && pol == POL_RETRY)
        retry_cnt <= code_d == RC_RTY ? retry_cnt + 4'd1 : 4'd0;
      if (state_q == S_DECIDE && code_d == RC_PENDING) slot_q <= cur_q;
      slot_busy <= (slot_busy && !rdy_fire) || (state_q == S_DECIDE && code_d == RC_PENDING);
      slot_armed <= (slot_armed && !rdy_fire) || (resp_fire && rsp_code_q == RC_PENDING);
      delay_cnt <= resp_fire && rsp_code_q == RC_PENDING ? cfg_rdy_delay :
                   slot_armed && delay_cnt != 16'd0 ? delay_cnt - 16'd1 : delay_cnt;
      host_int_valid <= deliver;
      if (deliver) begin
        host_int_obj <= in_resp ? cur_q.obj[63:0] : slot_q.obj[63:0];
        host_int_pasid <= in_resp ? cur_q.pasid : slot_q.pasid;
        host_int_actag <= in_resp ? cur_q.actag : slot_q.actag;
      end
      err_overflow <= err_overflow || (cmd_valid && full && !pop);
    end
  end
`ifdef INTRP_RSP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_done <= '0;
      stat_retry <= '0;
      stat_pending <= '0;
      stat_fail <= '0;
    end else if (resp_fire || rdy_fire) begin
      if (rsp_code == RC_DONE && stat_done != '1) stat_done <= stat_done + 32'd1;
      if (rsp_code == RC_RTY && stat_retry != '1) stat_retry <= stat_retry + 32'd1;
      if (rsp_code == RC_PENDING && stat_pending != '1) stat_pending <= stat_pending + 32'd1;
      if (rsp_code == RC_FAILED && stat_fail != '1) stat_fail <= stat_fail + 32'd1;
    end
  end
`endif
endmodule
